game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the VGA flappy-bird design. It sits between the keyboard decoder, the mover, the score display and pixel_gen, and it owns the game state. Once per video frame it evaluates bird/pipe collision and pipe-pass scoring from the mover's coordinates. It drives the world reset, the run enable, the flap request and the score/game-over outputs that the rest of the design consumes.

## Interface
- PIPE_W, 60: pipe column width in pixels
- GAP_H, 120: vertical gap height in pixels; gap spans pipe_y .. pipe_y+GAP_H-1
- BIRD_SZ, 20: bird square side in pixels
- FLOOR_Y, 440: first floor row; touching it is fatal
- DEATH_FRAMES, 60: frames spent in DYING before OVER
- clk  in  1  system clock (same clock as keyboard/score)
- reset  in  1  synchronous, active-high; one clock, sync reset
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blanking
- start  in  1  start button level; the block edge-detects it internally
- flap_key  in  1  level from keyboard (dir[0]); the block edge-detects it internally
- bird_x, bird_y  in  10 each  bird top-left
- pipe1_x..pipe3_x, pipe1_y..pipe3_y  in  10 each  pipe left edge / gap top
- world_rst  out  1  reset to mover and score, asserted in IDLE
- run  out  1  mover advance enable, high only in PLAY
- flap  out  1  one-cycle flap request to mover
- score_inc  out  1  one-cycle pulse per pipe passed
- score  out  8  current score
- best  out  8  best score since reset
- game_over  out  1  high in OVER
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3

## Operation
- States:
  - IDLE: world_rst=1, run=0.
  - PLAY: run=1.
  - DYING: run=0, frame counter counts down.
  - OVER: game_over=1; holds the final score.
- Transitions:
  - IDLE→PLAY on a start rising edge or a flap_key rising edge. A flap_key edge also emits flap in the same cycle as the transition.
  - PLAY→DYING when the collision check is true on a frame_tick.
  - DYING→OVER after DEATH_FRAMES frame_ticks.
  - OVER→IDLE on a start rising edge. flap_key is ignored in OVER.
- Edge detect: register each input once and compare to its previous value. A rising edge is cur & ~prev. A held key produces exactly one edge.
- flap: emitted only in PLAY (plus the IDLE→PLAY case above), at most one per frame. Further edges before the next frame_tick are dropped.
- Collision, computed combinationally in 11-bit arithmetic with no wrap, for pipe i:
  - Horizontal overlap: bird_x+BIRD_SZ > pipe_x AND bird_x < pipe_x+PIPE_W.
  - Collision with pipe i: overlap AND (bird_y < pipe_y OR bird_y+BIRD_SZ > pipe_y+GAP_H).
  - Global collision: any pipe collides, OR bird_y+BIRD_SZ > FLOOR_Y, OR bird_y == 0.
- Pass scoring:
  - Per-pipe flag behind_i = (pipe_x+PIPE_W < bird_x), sampled on frame_tick in PLAY.
  - A 0→1 transition of behind_i is a pass. A pipe wrapping to the right edge returns its flag to 0.
  - Several passes in one frame each count; score_inc is high for one cycle, and score adds the pass count.
  - score saturates at 255.
- Collision has priority: if collision and pass occur on the same tick, there is no increment and the state goes to DYING.
- Entering IDLE clears score and all behind flags.
- On the OVER entry cycle, best <= max(best, score). best is cleared only by reset.

## Timing
- Reset values:
  - State: state=IDLE.
  - Outputs: world_rst=1, run=0, flap=0, score_inc=0, score=0, best=0, game_over=0.
  - Internal: edge registers=0, death counter=0.
- State outputs are registered and valid the cycle after the transition.
- Collision and pass are evaluated only in the frame_tick cycle. Their results (state change, score_inc, score) appear on the next clock.
- The DYING counter loads DEATH_FRAMES-1 on entry and decrements per frame_tick. At 0 with a frame_tick the state goes to OVER. DEATH_FRAMES=1 gives OVER one frame after death.
- Reset asserted mid-game takes effect on the next clock edge and overrides all events in that cycle.
- Simultaneous start and flap_key edges in IDLE produce one transition and one flap pulse.

## Test plan
- Reset, then a start edge: state goes 0→1 one cycle later, world_rst 1→0, run=1, score=0.
- In PLAY with pipe1_x=100, bird_x=170, PIPE_W=60:
  - Tick with pipe1_x=110: no pass (110+60=170, not < 170).
  - Tick with pipe1_x=109: score_inc pulse, score=1.
  - A further tick at the same position: no second increment.
- Bird at x=100, y=200; pipe_x=90, pipe_y=210: collision on tick, state=2, run=0. After 60 further ticks, state=3, game_over=1, best=score.
- Bird y=421 (421+20>440), no pipe overlap: DYING on the next tick. Same with bird y=0.
- flap_key held high for 3 frames in PLAY: exactly one flap pulse. Three toggles within one frame: one flap pulse.
- Score 255 plus a pass: score stays 255. Collision and pass on the same tick: score unchanged, state=DYING. Reset asserted in DYING: IDLE and best=0 next cycle.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer for the flappy-bird design: owns IDLE/PLAY/DYING/OVER, evaluates
// collision and pipe-pass scoring once per frame, and drives flap/score/best outputs.
module game_ctrl #(
  parameter int unsigned PIPE_W       = 60,
  parameter int unsigned GAP_H        = 120,
  parameter int unsigned BIRD_SZ      = 20,
  parameter int unsigned FLOOR_Y      = 440,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       flap_key,
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_y,
  input  logic [9:0] pipe1_x,
  input  logic [9:0] pipe2_x,
  input  logic [9:0] pipe3_x,
  input  logic [9:0] pipe1_y,
  input  logic [9:0] pipe2_y,
  input  logic [9:0] pipe3_y,
  output logic       world_rst,
  output logic       run,
  output logic       flap,
  output logic       score_inc,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int unsigned   CNT_W    = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [10:0]   SZ11     = 11'(BIRD_SZ);
  localparam logic [10:0]   PW11     = 11'(PIPE_W);
  localparam logic [10:0]   GAP11    = 11'(GAP_H);
  localparam logic [10:0]   FLOOR11  = 11'(FLOOR_Y);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       best_q, best_d;
  logic [2:0]       behind_q, behind_d;
  logic             flap_q, flap_d;
  logic             score_inc_q, score_inc_d;
  logic             flapped_q, flapped_d;
  logic             start_q, flap_key_q;

  logic start_rise, flap_rise;
  assign start_rise = start & ~start_q;
  assign flap_rise  = flap_key & ~flap_key_q;

  // Per-pipe geometry, widened to 11 bits so sums never wrap.
  logic [9:0]  pipe_x [3];
  logic [9:0]  pipe_y [3];
  logic [10:0] bx11, by11;
  logic [2:0]  pipe_hit, behind_now;

  assign pipe_x = '{pipe1_x, pipe2_x, pipe3_x};
  assign pipe_y = '{pipe1_y, pipe2_y, pipe3_y};
  assign bx11   = {1'b0, bird_x};
  assign by11   = {1'b0, bird_y};

  for (genvar i = 0; i < 3; i++) begin : g_pipe
    logic [10:0] px11, py11;
    logic        overlap;
    assign px11          = {1'b0, pipe_x[i]};
    assign py11          = {1'b0, pipe_y[i]};
    assign overlap       = (bx11 + SZ11 > px11) && (bx11 < px11 + PW11);
    assign pipe_hit[i]   = overlap && ((by11 < py11) || (by11 + SZ11 > py11 + GAP11));
    assign behind_now[i] = (px11 + PW11 < bx11);
  end

  logic       hit;
  logic [2:0] pass_vec;
  logic [1:0] pass_cnt;
  logic [8:0] score_sum;
  logic [7:0] score_sat;

  assign hit       = (|pipe_hit) || (by11 + SZ11 > FLOOR11) || (bird_y == 10'd0);
  assign pass_vec  = behind_now & ~behind_q;
  assign pass_cnt  = 2'(pass_vec[0]) + 2'(pass_vec[1]) + 2'(pass_vec[2]);
  assign score_sum = {1'b0, score_q} + 9'(pass_cnt);
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    best_d      = best_q;
    behind_d    = behind_q;
    flap_d      = 1'b0;
    score_inc_d = 1'b0;
    flapped_d   = frame_tick ? 1'b0 : flapped_q;

    unique case (state_q)
      IDLE: begin
        score_d   = '0;
        behind_d  = '0;
        flapped_d = 1'b0;
        if (start_rise || flap_rise) begin
          state_d   = PLAY;
          flap_d    = flap_rise;
          flapped_d = flap_rise;
        end
      end
      PLAY: begin
        // A frame_tick opens a new frame, so an edge on that same cycle is allowed.
        if (flap_rise && (!flapped_q || frame_tick)) begin
          flap_d    = 1'b1;
          flapped_d = 1'b1;
        end
        if (frame_tick) begin
          behind_d = behind_now;
          if (hit) begin
            state_d = DYING;
            cnt_d   = CNT_LOAD;
          end else if (pass_cnt != 2'd0) begin
            score_inc_d = 1'b1;
            score_d     = score_sat;
          end
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            state_d = OVER;
            best_d  = (score_q > best_q) ? score_q : best_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d  = IDLE;
          score_d  = '0;
          behind_d = '0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      score_q     <= '0;
      best_q      <= '0;
      behind_q    <= '0;
      flap_q      <= 1'b0;
      score_inc_q <= 1'b0;
      flapped_q   <= 1'b0;
      start_q     <= 1'b0;
      flap_key_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      best_q      <= best_d;
      behind_q    <= behind_d;
      flap_q      <= flap_d;
      score_inc_q <= score_inc_d;
      flapped_q   <= flapped_d;
      start_q     <= start;
      flap_key_q  <= flap_key;
    end
  end

  assign state     = state_q;
  assign world_rst = (state_q == IDLE);
  assign run       = (state_q == PLAY);
  assign game_over = (state_q == OVER);
  assign flap      = flap_q;
  assign score_inc = score_inc_q;
  assign score     = score_q;
  assign best      = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios with literal expectations,
// then randomized play, all compared every cycle against a behavioural game model.
module tb_game_ctrl;

  localparam int DEATH = 60;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, flap_key;
  logic [9:0] bird_x, bird_y;
  logic [9:0] pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y;
  logic       world_rst, run, flap, score_inc, game_over;
  logic [7:0] score, best;
  logic [1:0] state;

  game_ctrl #(.DEATH_FRAMES(DEATH)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .flap_key(flap_key),
    .bird_x(bird_x), .bird_y(bird_y),
    .pipe1_x(pipe1_x), .pipe2_x(pipe2_x), .pipe3_x(pipe3_x),
    .pipe1_y(pipe1_y), .pipe2_y(pipe2_y), .pipe3_y(pipe3_y),
    .world_rst(world_rst), .run(run), .flap(flap), .score_inc(score_inc),
    .score(score), .best(best), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Behavioural game model: states as plain integers, score rules as arithmetic.
  int m_state, m_score, m_best, m_left;
  bit m_flap, m_inc, m_flapped, p_start, p_flap, chk_en;
  bit m_behind [3];

  always @(posedge clk) begin
    int px [3];
    int py [3];
    int bx, by, passes;
    bit s_edge, f_edge, crash, now_behind;
    if (reset) begin
      m_state = 0; m_score = 0; m_best = 0; m_left = 0;
      m_flap = 0; m_inc = 0; m_flapped = 0; p_start = 0; p_flap = 0;
      m_behind = '{0, 0, 0};
      chk_en = 1;
    end else begin
      s_edge = start && !p_start;
      f_edge = flap_key && !p_flap;
      p_start = start;
      p_flap  = flap_key;
      m_flap = 0;
      m_inc  = 0;
      if (frame_tick) m_flapped = 0;
      px = '{int'(pipe1_x), int'(pipe2_x), int'(pipe3_x)};
      py = '{int'(pipe1_y), int'(pipe2_y), int'(pipe3_y)};
      bx = int'(bird_x);
      by = int'(bird_y);
      case (m_state)
        0: begin
          m_flapped = 0;
          if (s_edge || f_edge) begin
            m_state = 1;
            if (f_edge) begin m_flap = 1; m_flapped = 1; end
          end
        end
        1: begin
          if (f_edge && !m_flapped) begin m_flap = 1; m_flapped = 1; end
          if (frame_tick) begin
            crash  = (by + 20 > 440) || (by == 0);
            passes = 0;
            for (int i = 0; i < 3; i++) begin
              if (bx + 20 > px[i] && bx < px[i] + 60 && (by < py[i] || by + 20 > py[i] + 120))
                crash = 1;
              now_behind = (px[i] + 60 < bx);
              if (now_behind && !m_behind[i]) passes++;
              m_behind[i] = now_behind;
            end
            if (crash) begin
              m_state = 2;
              m_left  = DEATH;
            end else if (passes > 0) begin
              m_inc   = 1;
              m_score = (m_score + passes > 255) ? 255 : m_score + passes;
            end
          end
        end
        2: begin
          if (frame_tick) begin
            m_left--;
            if (m_left == 0) begin
              m_state = 3;
              if (m_score > m_best) m_best = m_score;
            end
          end
        end
        default: begin
          if (s_edge) begin
            m_state = 0;
            m_score = 0;
            m_behind = '{0, 0, 0};
          end
        end
      endcase
    end
  end

  int flap_seen = 0;

  always @(negedge clk) begin
    logic [22:0] got, exp;
    if (flap) flap_seen++;
    if (chk_en) begin
      got = {state, world_rst, run, flap, score_inc, score, best, game_over};
      exp = {m_state[1:0], m_state == 0, m_state == 1, m_flap, m_inc,
             m_score[7:0], m_best[7:0], m_state == 3};
      check("model_outputs", got, exp);
    end
  end

  task automatic cyc(input bit st, input bit fk, input bit tk);
    @(negedge clk);
    start = st; flap_key = fk; frame_tick = tk;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int bx, input int by, input int p1x, input int p2x,
                         input int p3x, input int gy);
    bird_x = 10'(bx); bird_y = 10'(by);
    pipe1_x = 10'(p1x); pipe2_x = 10'(p2x); pipe3_x = 10'(p3x);
    pipe1_y = 10'(gy); pipe2_y = 10'(gy); pipe3_y = 10'(gy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; flap_key = 0; frame_tick = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int f0;
    int gap;
    reset = 1; start = 0; flap_key = 0; frame_tick = 0;
    set_pos(170, 200, 600, 700, 800, 150);
    repeat (2) @(negedge clk);
    check("reset_state", state, 0);
    check("reset_outputs", {world_rst, run, flap, score_inc, game_over}, 5'b10000);
    check("reset_score_best", {score, best}, 16'h0000);
    reset = 0;

    // Start edge: PLAY one cycle later.
    cyc(1, 0, 0); settle;
    check("start_state", state, 1);
    check("start_wrst_run", {world_rst, run}, 2'b01);
    check("start_score", score, 0);

    // Pass boundary at pipe_x+PIPE_W == bird_x.
    set_pos(170, 200, 110, 600, 800, 150);
    cyc(0, 0, 1); settle;
    check("no_pass_at_170", {score_inc, score}, 9'd0);
    pipe1_x = 10'd109;
    cyc(0, 0, 1); settle;
    check("pass_inc", score_inc, 1);
    check("pass_score", score, 1);
    cyc(0, 0, 1); settle;
    check("no_second_pass", {score_inc, score}, {1'b0, 8'd1});

    // Held flap key over three frames, then three toggles within one frame.
    f0 = flap_seen;
    for (int fr = 0; fr < 3; fr++) begin
      cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
    end
    cyc(0, 0, 0); cyc(0, 0, 0); settle;
    check("held_flap_pulses", flap_seen - f0, 1);
    cyc(0, 0, 1);
    f0 = flap_seen;
    for (int t = 0; t < 3; t++) begin
      cyc(0, 1, 0); cyc(0, 0, 0);
    end
    cyc(0, 0, 0); settle;
    check("toggle_flap_pulses", flap_seen - f0, 1);

    // Pipe collision, then DEATH frames to OVER.
    set_pos(100, 200, 90, 600, 800, 210);
    cyc(0, 0, 1); settle;
    check("pipe_hit_state", state, 2);
    check("pipe_hit_run", run, 0);
    repeat (DEATH - 1) cyc(0, 0, 1);
    settle;
    check("dying_still", state, 2);
    cyc(0, 0, 1); settle;
    check("over_state", state, 3);
    check("over_flags", {game_over, best}, {1'b1, 8'd1});

    // OVER ignores flap; start returns to IDLE keeping best.
    cyc(0, 1, 0); settle;
    check("over_ignores_flap", {state, flap}, {2'd3, 1'b0});
    cyc(0, 0, 0);
    cyc(1, 0, 0); settle;
    check("over_to_idle", {state, score, best}, {2'd0, 8'd0, 8'd1});

    // Floor collision, then reset during DYING.
    set_pos(100, 421, 600, 700, 800, 150);
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 1); settle;
    check("floor_hit", state, 2);
    @(negedge clk); reset = 1; settle;
    check("reset_in_dying", {state, best}, {2'd0, 8'd0});
    @(negedge clk); reset = 0;

    // Top-edge collision at bird_y == 0.
    set_pos(100, 0, 600, 700, 800, 150);
    cyc(1, 0, 0); cyc(0, 0, 1); settle;
    check("top_hit", state, 2);
    do_reset();

    // Score saturation: three passes per round.
    set_pos(500, 200, 600, 600, 600, 150);
    cyc(1, 0, 0);
    for (int r = 0; r < 85; r++) begin
      set_pos(500, 200, 600, 600, 600, 150); cyc(0, 0, 1);
      set_pos(500, 200, 10, 10, 10, 150);    cyc(0, 0, 1);
    end
    settle;
    check("score_255", score, 255);
    set_pos(500, 200, 600, 600, 600, 150); cyc(0, 0, 1);
    set_pos(500, 200, 10, 10, 10, 150);    cyc(0, 0, 1);
    settle;
    check("score_saturated", score, 255);

    // Collision and pass on the same tick: no increment.
    set_pos(500, 200, 600, 600, 600, 150); cyc(0, 0, 1);
    set_pos(500, 421, 10, 600, 600, 150);  cyc(0, 0, 1);
    settle;
    check("hit_beats_pass", {state, score_inc, score}, {2'd2, 1'b0, 8'd255});
    do_reset();

    // Randomized play.
    gap = 150;
    set_pos(200, 200, 300, 520, 740, gap);
    for (int c = 0; c < 6000; c++) begin
      bit tk;
      tk = (c % 3 == 0);
      @(negedge clk);
      reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) flap_key = ~flap_key;
      frame_tick = tk;
      if (tk) begin
        if ($urandom_range(0, 19) == 0) gap = $urandom_range(40, 280);
        pipe1_x = (pipe1_x < 10'd30) ? 10'($urandom_range(560, 640)) : pipe1_x - 10'($urandom_range(0, 25));
        pipe2_x = (pipe2_x < 10'd30) ? 10'($urandom_range(560, 640)) : pipe2_x - 10'($urandom_range(0, 25));
        pipe3_x = (pipe3_x < 10'd30) ? 10'($urandom_range(560, 640)) : pipe3_x - 10'($urandom_range(0, 25));
        pipe1_y = 10'(gap); pipe2_y = 10'(gap); pipe3_y = 10'(gap);
        case ($urandom_range(0, 15))
          0:       bird_y = 10'd0;
          1:       bird_y = 10'($urandom_range(415, 430));
          2:       bird_y = 10'($urandom_range(1, 439));
          default: bird_y = 10'(gap + $urandom_range(0, 100));
        endcase
        bird_x = 10'($urandom_range(150, 250));
      end
    end
    @(negedge clk);
    reset = 0; start = 0; flap_key = 0; frame_tick = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
